// File: rtl/pipeline_cpu_top.sv
// Board top: single-stepped 3-stage 8-bit CPU with a fixed program, state shown on a 16x2 LCD.
// BTN3 rising edges advance the pipeline; the LCD is refreshed continuously through its 4-bit bus.
module pipeline_cpu_top #(
    parameter int INIT_WAIT  = 750000,
    parameter int E_HIGH     = 12,
    parameter int NIB_GAP    = 50,
    parameter int CHAR_GAP   = 2000,
    parameter int CLEAR_WAIT = 82000
) (
    input  logic       CCLK,
    input  logic       BTN2,
    input  logic       BTN3,
    input  logic [3:0] SW,
    output logic       LED,
    output logic       LCDE,
    output logic       LCDRS,
    output logic       LCDRW,
    output logic [3:0] LCDDAT
);

    localparam int M1 = (INIT_WAIT > CLEAR_WAIT) ? INIT_WAIT : CLEAR_WAIT;
    localparam int M2 = (M1 > CHAR_GAP) ? M1 : CHAR_GAP;
    localparam int M3 = (M2 > NIB_GAP) ? M2 : NIB_GAP;
    localparam int MAXWAIT = (M3 > E_HIGH) ? M3 : E_HIGH;
    localparam int CW = $clog2(MAXWAIT + 1);

    localparam logic [3:0] OP_LI   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_BNZ  = 4'd6;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] rd;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] imm;
    } idex_t;

    typedef enum logic [2:0] {
        LS_INIT,
        LS_SETUP,
        LS_PULSE,
        LS_HOLD,
        LS_NIBGAP,
        LS_GAP
    } lcd_state_t;

    logic unused_sw;
    assign unused_sw = ^SW[3:2];

    // ---------------- step generation ----------------
    logic sync1, sync2, prev, step;

    always_ff @(posedge CCLK) begin
        if (!BTN2) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            step  <= 1'b0;
        end else begin
            sync1 <= BTN3;
            sync2 <= sync1;
            prev  <= sync2;
            step  <= sync2 & ~prev;
        end
    end

    // ---------------- pipeline ----------------
    logic [3:0]  pc;
    logic [15:0] ifid;
    idex_t       idex;
    logic [7:0]  rf [4];
    logic [15:0] stepcnt;
    logic        led;

    logic       ex_we, ex_taken;
    logic [7:0] ex_res;
    logic [7:0] id_a, id_b;

    function automatic logic [15:0] rom(input logic [3:0] addr);
        case (addr)
            4'd0:    rom = 16'h1003;
            4'd1:    rom = 16'h1401;
            4'd2:    rom = 16'h3100;
            4'd3:    rom = 16'h4805;
            4'd4:    rom = 16'h6002;
            4'd5:    rom = 16'h5005;
            default: rom = 16'h0000;
        endcase
    endfunction

    always_comb begin
        ex_we    = 1'b0;
        ex_taken = 1'b0;
        ex_res   = 8'h00;
        case (idex.op)
            OP_LI:   begin ex_we = 1'b1; ex_res = idex.imm; end
            OP_ADD:  begin ex_we = 1'b1; ex_res = idex.a + idex.b; end
            OP_SUB:  begin ex_we = 1'b1; ex_res = idex.a - idex.b; end
            OP_ADDI: begin ex_we = 1'b1; ex_res = idex.a + idex.imm; end
            OP_JMP:  ex_taken = 1'b1;
            OP_BNZ:  ex_taken = (idex.a != 8'h00);
            default: ;
        endcase
    end

    // The EX write lands on the same step edge as the ID read, so bypass it here.
    always_comb begin
        id_a = rf[ifid[11:10]];
        id_b = rf[ifid[9:8]];
        if (ex_we && (idex.rd == ifid[11:10])) id_a = ex_res;
        if (ex_we && (idex.rd == ifid[9:8]))   id_b = ex_res;
    end

    always_ff @(posedge CCLK) begin
        if (!BTN2) begin
            pc      <= 4'd0;
            ifid    <= 16'h0000;
            idex    <= '0;
            stepcnt <= 16'h0000;
            led     <= 1'b0;
            for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
        end else if (step) begin
            stepcnt <= stepcnt + 16'd1;
            led     <= ~led;
            if (ex_we) rf[idex.rd] <= ex_res;
            if (ex_taken) begin
                pc   <= idex.imm[3:0];
                ifid <= 16'h0000;
                idex <= '0;
            end else begin
                pc   <= pc + 4'd1;
                ifid <= rom(pc);
                idex <= '{op: ifid[15:12], rd: ifid[11:10], a: id_a, b: id_b, imm: ifid[7:0]};
            end
        end
    end

    // ---------------- LCD driver ----------------
    // idx 0-3 init nibbles, 4-7 setup commands, 8 set-address, 9-24 the 16 characters.
    lcd_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0]  idx, idx_n;
    logic [3:0]  dat, dat_n;
    logic        rs, rs_n, low, low_n, single, single_n, lcde, load;
    logic [7:0]  curbyte, byte_n;
    logic [7:0]  item_byte;
    logic        item_rs, item_single;
    logic [3:0]  snap_pc;
    logic [7:0]  snap_reg;
    logic [1:0]  snap_sel;
    logic [15:0] snap_cnt;

    function automatic logic [7:0] hexchar(input logic [3:0] d);
        hexchar = (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

    always_comb begin
        item_byte   = 8'h00;
        item_rs     = 1'b1;
        item_single = 1'b0;
        case (idx)
            5'd0, 5'd1, 5'd2: begin item_byte = 8'h30; item_rs = 1'b0; item_single = 1'b1; end
            5'd3:  begin item_byte = 8'h20; item_rs = 1'b0; item_single = 1'b1; end
            5'd4:  begin item_byte = 8'h28; item_rs = 1'b0; end
            5'd5:  begin item_byte = 8'h06; item_rs = 1'b0; end
            5'd6:  begin item_byte = 8'h0C; item_rs = 1'b0; end
            5'd7:  begin item_byte = 8'h01; item_rs = 1'b0; end
            5'd8:  begin item_byte = 8'h80; item_rs = 1'b0; end
            5'd9:  item_byte = 8'h50;
            5'd10: item_byte = 8'h43;
            5'd11: item_byte = 8'h3D;
            5'd12: item_byte = 8'h30;
            5'd13: item_byte = hexchar(snap_pc);
            5'd14: item_byte = 8'h20;
            5'd15: item_byte = 8'h52;
            5'd16: item_byte = 8'h30 + {6'd0, snap_sel};
            5'd17: item_byte = 8'h3D;
            5'd18: item_byte = hexchar(snap_reg[7:4]);
            5'd19: item_byte = hexchar(snap_reg[3:0]);
            5'd20: item_byte = 8'h20;
            5'd21: item_byte = hexchar(snap_cnt[15:12]);
            5'd22: item_byte = hexchar(snap_cnt[11:8]);
            5'd23: item_byte = hexchar(snap_cnt[7:4]);
            5'd24: item_byte = hexchar(snap_cnt[3:0]);
            default: item_byte = 8'h20;
        endcase
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        dat_n    = dat;
        rs_n     = rs;
        low_n    = low;
        single_n = single;
        byte_n   = curbyte;
        load     = 1'b0;
        case (state)
            LS_INIT: begin
                if (cnt == '0) load = 1'b1;
                else cnt_n = cnt - CW'(1);
            end
            LS_SETUP: begin
                if (cnt == '0) begin
                    state_n = LS_PULSE;
                    cnt_n   = CW'(E_HIGH - 1);
                end else cnt_n = cnt - CW'(1);
            end
            LS_PULSE: begin
                if (cnt == '0) begin
                    state_n = LS_HOLD;
                    cnt_n   = CW'(1);
                end else cnt_n = cnt - CW'(1);
            end
            LS_HOLD: begin
                if (cnt == '0) begin
                    if (!low && !single) begin
                        state_n = LS_NIBGAP;
                        cnt_n   = CW'(NIB_GAP - 1);
                    end else begin
                        state_n = LS_GAP;
                        cnt_n   = (idx == 5'd7) ? CW'(CLEAR_WAIT - 1) : CW'(CHAR_GAP - 1);
                        idx_n   = (idx == 5'd24) ? 5'd8 : idx + 5'd1;
                    end
                end else cnt_n = cnt - CW'(1);
            end
            LS_NIBGAP: begin
                if (cnt == '0) begin
                    state_n = LS_SETUP;
                    cnt_n   = CW'(1);
                    dat_n   = curbyte[3:0];
                    low_n   = 1'b1;
                end else cnt_n = cnt - CW'(1);
            end
            LS_GAP: begin
                if (cnt == '0) load = 1'b1;
                else cnt_n = cnt - CW'(1);
            end
            default: state_n = LS_INIT;
        endcase
        if (load) begin
            state_n  = LS_SETUP;
            cnt_n    = CW'(1);
            dat_n    = item_byte[7:4];
            rs_n     = item_rs;
            byte_n   = item_byte;
            single_n = item_single;
            low_n    = 1'b0;
        end
    end

    // LCDE is registered from the next state so the strobe is glitch-free.
    always_ff @(posedge CCLK) begin
        if (!BTN2) begin
            state   <= LS_INIT;
            cnt     <= CW'(INIT_WAIT - 1);
            idx     <= 5'd0;
            dat     <= 4'h0;
            rs      <= 1'b0;
            low     <= 1'b0;
            single  <= 1'b0;
            curbyte <= 8'h00;
            lcde    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            dat     <= dat_n;
            rs      <= rs_n;
            low     <= low_n;
            single  <= single_n;
            curbyte <= byte_n;
            lcde    <= (state_n == LS_PULSE);
        end
    end

    always_ff @(posedge CCLK) begin
        if (!BTN2) begin
            snap_pc  <= 4'd0;
            snap_reg <= 8'h00;
            snap_sel <= 2'd0;
            snap_cnt <= 16'h0000;
        end else if (load && (idx == 5'd8)) begin
            snap_pc  <= pc;
            snap_reg <= rf[SW[1:0]];
            snap_sel <= SW[1:0];
            snap_cnt <= stepcnt;
        end
    end

    assign LED    = led;
    assign LCDE   = lcde;
    assign LCDRS  = rs;
    assign LCDRW  = 1'b0;
    assign LCDDAT = dat;

endmodule

// File: tb/tb_pipeline_cpu_top.sv
// Directed bench for pipeline_cpu_top: per-step golden table plus LCD stream decoding.
// Uses shortened LCD timing parameters so a full init and refresh fit in a short run.
module tb_pipeline_cpu_top;

    localparam int IW = 200;
    localparam int EH = 4;
    localparam int NG = 6;
    localparam int CG = 20;
    localparam int CWAIT = 60;

    logic       CCLK = 1'b0;
    logic       BTN2 = 1'b0;
    logic       BTN3 = 1'b0;
    logic [3:0] SW = 4'd0;
    logic       LED, LCDE, LCDRS, LCDRW;
    logic [3:0] LCDDAT;

    pipeline_cpu_top #(
        .INIT_WAIT(IW), .E_HIGH(EH), .NIB_GAP(NG), .CHAR_GAP(CG), .CLEAR_WAIT(CWAIT)
    ) dut (
        .CCLK(CCLK), .BTN2(BTN2), .BTN3(BTN3), .SW(SW), .LED(LED),
        .LCDE(LCDE), .LCDRS(LCDRS), .LCDRW(LCDRW), .LCDDAT(LCDDAT)
    );

    always #5 CCLK = ~CCLK;

    typedef struct {
        logic [3:0] pc;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
    } vec_t;

    vec_t       vecs [40];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] initnib [$];
    logic [8:0] byteq [$];
    int         nibcnt = 0;
    int         cyc = 0;
    int         first_rise = -1;
    logic [8:0] expcmd [5];

    // Decodes the LCD bus: nibbles are latched on each LCDE falling edge.
    initial begin
        logic       lcde_q;
        logic [3:0] hinib;
        logic       hirs;
        lcde_q = 1'b0;
        hinib = 4'h0;
        hirs = 1'b0;
        forever begin
            @(negedge CCLK);
            if (!BTN2) begin
                initnib.delete();
                byteq.delete();
                nibcnt = 0;
                cyc = 0;
                first_rise = -1;
                lcde_q = 1'b0;
            end else begin
                cyc++;
                if (LCDE && first_rise < 0) first_rise = cyc;
                if (lcde_q && !LCDE) begin
                    if (nibcnt < 4) initnib.push_back(LCDDAT);
                    else if ((nibcnt % 2) == 0) begin
                        hinib = LCDDAT;
                        hirs = LCDRS;
                    end else byteq.push_back({hirs, hinib, LCDDAT});
                    nibcnt++;
                end
                lcde_q = LCDE;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        @(negedge CCLK);
        BTN3 = 1'b1;
        repeat (35) @(negedge CCLK);
        BTN3 = 1'b0;
        repeat (35) @(negedge CCLK);
    endtask

    function automatic int find_cmd(input int from, input int nth);
        int seen = 0;
        for (int i = from; i < byteq.size(); i++) begin
            if (byteq[i] == 9'h080) begin
                seen++;
                if (seen == nth) return i;
            end
        end
        return -1;
    endfunction

    initial begin
        string expected_text;
        int    mark, pos, pulses, firstp;

        vecs[0]  = '{4'd1, 8'd0, 8'd0, 8'd0};
        vecs[1]  = '{4'd2, 8'd0, 8'd0, 8'd0};
        vecs[2]  = '{4'd3, 8'd3, 8'd0, 8'd0};
        vecs[3]  = '{4'd4, 8'd3, 8'd1, 8'd0};
        vecs[4]  = '{4'd5, 8'd2, 8'd1, 8'd0};
        vecs[5]  = '{4'd6, 8'd2, 8'd1, 8'd5};
        vecs[6]  = '{4'd2, 8'd2, 8'd1, 8'd5};
        vecs[7]  = '{4'd3, 8'd2, 8'd1, 8'd5};
        vecs[8]  = '{4'd4, 8'd2, 8'd1, 8'd5};
        vecs[9]  = '{4'd5, 8'd1, 8'd1, 8'd5};
        vecs[10] = '{4'd6, 8'd1, 8'd1, 8'd10};
        vecs[11] = '{4'd2, 8'd1, 8'd1, 8'd10};
        vecs[12] = '{4'd3, 8'd1, 8'd1, 8'd10};
        vecs[13] = '{4'd4, 8'd1, 8'd1, 8'd10};
        vecs[14] = '{4'd5, 8'd0, 8'd1, 8'd10};
        vecs[15] = '{4'd6, 8'd0, 8'd1, 8'd15};
        vecs[16] = '{4'd7, 8'd0, 8'd1, 8'd15};
        for (int i = 17; i < 40; i++) vecs[i] = '{4'(5 + (i - 14) % 3), 8'd0, 8'd1, 8'd15};
        expcmd[0] = 9'h028;
        expcmd[1] = 9'h006;
        expcmd[2] = 9'h00C;
        expcmd[3] = 9'h001;
        expcmd[4] = 9'h080;

        $display("[TB] reset");
        repeat (2) @(negedge CCLK);
        checkOutput("rst_led", LED, 0);
        checkOutput("rst_lcde", LCDE, 0);
        checkOutput("rst_lcdrw", LCDRW, 0);
        checkOutput("rst_lcdrs", LCDRS, 0);
        checkOutput("rst_lcddat", LCDDAT, 0);
        checkOutput("rst_pc", dut.pc, 0);
        checkOutput("rst_stepcnt", dut.stepcnt, 0);
        for (int r = 0; r < 4; r++) checkOutput($sformatf("rst_r%0d", r), dut.rf[r], 0);
        BTN2 = 1'b1;

        $display("[TB] stepping program");
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            checkOutput($sformatf("step%0d_pc", i + 1), dut.pc, vecs[i].pc);
            checkOutput($sformatf("step%0d_r0", i + 1), dut.rf[0], vecs[i].r0);
            checkOutput($sformatf("step%0d_r1", i + 1), dut.rf[1], vecs[i].r1);
            checkOutput($sformatf("step%0d_r2", i + 1), dut.rf[2], vecs[i].r2);
            checkOutput($sformatf("step%0d_r3", i + 1), dut.rf[3], 0);
            checkOutput($sformatf("step%0d_led", i + 1), LED, (i + 1) % 2);
            checkOutput($sformatf("step%0d_cnt", i + 1), dut.stepcnt, i + 1);
        end

        checkOutput("init_wait_min", first_rise > IW, 1);
        checkOutput("init_wait_max", first_rise <= IW + 4, 1);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("init_nib%0d", i), (initnib.size() > i) ? initnib[i] : 32'hDEAD, (i < 3) ? 3 : 2);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("init_cmd%0d", i), (byteq.size() > i) ? byteq[i] : 32'hDEAD, expcmd[i]);

        $display("[TB] display refresh");
        SW = 4'd2;
        mark = byteq.size();
        pos = -1;
        for (int t = 0; t < 5000 && pos < 0; t++) begin
            @(negedge CCLK);
            pos = find_cmd(mark, 2);
        end
        checkOutput("lcd_addr_cmd_seen", pos >= 0, 1);
        if (pos >= 0) begin
            for (int t = 0; t < 2000 && byteq.size() < pos + 17; t++) @(negedge CCLK);
            checkOutput("lcd_refresh_complete", byteq.size() >= pos + 17, 1);
            expected_text = "PC=06 R2=0F 0028";
            for (int i = 0; i < 16; i++)
                checkOutput($sformatf("lcd_char%0d", i),
                            (byteq.size() > pos + 1 + i) ? byteq[pos + 1 + i] : 32'hDEAD,
                            {1'b1, expected_text[i]});
        end

        $display("[TB] held button");
        @(negedge CCLK);
        BTN3 = 1'b1;
        pulses = 0;
        firstp = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge CCLK);
            if (dut.step) begin
                pulses++;
                if (firstp < 0) firstp = i;
            end
        end
        BTN3 = 1'b0;
        repeat (10) @(negedge CCLK);
        checkOutput("hold_pulses", pulses, 1);
        checkOutput("hold_pulse_delay", firstp, 3);
        checkOutput("hold_cnt", dut.stepcnt, 41);
        checkOutput("hold_led", LED, 1);

        $display("[TB] reset during LCD transfer");
        for (int t = 0; t < 3000 && !LCDE; t++) @(negedge CCLK);
        checkOutput("lcd_busy_seen", LCDE, 1);
        BTN2 = 1'b0;
        BTN3 = 1'b1;
        @(negedge CCLK);
        checkOutput("abort_lcde", LCDE, 0);
        checkOutput("abort_lcdrs", LCDRS, 0);
        checkOutput("abort_lcddat", LCDDAT, 0);
        checkOutput("abort_led", LED, 0);
        checkOutput("abort_pc", dut.pc, 0);
        checkOutput("abort_cnt", dut.stepcnt, 0);
        BTN3 = 1'b0;
        @(negedge CCLK);
        BTN2 = 1'b1;
        for (int t = 0; t < IW + 100 && first_rise < 0; t++) @(negedge CCLK);
        checkOutput("reinit_wait_min", first_rise > IW, 1);
        checkOutput("reinit_wait_max", (first_rise > 0) && (first_rise <= IW + 4), 1);
        checkOutput("reinit_no_step", dut.stepcnt, 0);
        for (int t = 0; t < 100 && initnib.size() == 0; t++) @(negedge CCLK);
        checkOutput("reinit_nib0", (initnib.size() > 0) ? initnib[0] : 32'hDEAD, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_cpu_top.md
Name: pipeline_cpu_top

Overview:
- Board-level top for a single-stepped 3-stage pipelined 8-bit CPU with a fixed internal program.
- Each debounced rising edge of BTN3 advances the pipeline one step.
- CPU state (PC, a selected register, step count) is continuously shown on a 16x2 character LCD through its 4-bit interface.

Parameters:
- INIT_WAIT, 750000: power-up wait in clock cycles before the first LCD nibble.
- E_HIGH, 12: LCDE high time in cycles per nibble; data is set up 2 cycles before E rises and held 2 cycles after it falls.
- NIB_GAP, 50: idle cycles between the two nibbles of one byte.
- CHAR_GAP, 2000: idle cycles after each byte.
- CLEAR_WAIT, 82000: idle cycles after the clear command 0x01.

Ports:
- CCLK  in  1  system clock; all logic on its rising edge.
- BTN2  in  1  reset; synchronous, active-low.
- BTN3  in  1  step button; asynchronous, level.
- SW  in  4  SW[1:0] selects the displayed register r0..r3; SW[3:2] ignored.
- LED  out  1  toggles on every accepted step.
- LCDE  out  1  LCD enable strobe.
- LCDRS  out  1  LCD register select: 0 = command, 1 = data.
- LCDRW  out  1  LCD read/write; constant 0 (write only).
- LCDDAT  out  4  LCD data nibble, high nibble first.

Behaviour:
- **Reset** (BTN2=0 at a CCLK edge):
  - PC=0, r0..r3=0, both pipeline registers hold NOP, step counter=0, LED=0.
  - BTN3 synchronizers are cleared.
  - LCD FSM returns to the INIT_WAIT state; LCDE=0, LCDRS=0, LCDDAT=0.
  - Reset asserted mid-operation aborts any LCD transfer immediately.
- **Step generation**:
  - BTN3 passes through 2 flip-flops, then a rising-edge detect.
  - Each edge produces a one-cycle step pulse, 3 cycles after BTN3 rises.
  - Holding BTN3 high gives exactly one step; BTN3 is ignored while BTN2=0.
- **Instruction format** (16 bits): op[15:12], rd[11:10], rs[9:8], imm[7:0]. Register file is 4 x 8 bits.
- **Opcodes**:
  - 1 LI: rd=imm.
  - 2 ADD: rd=rd+rs.
  - 3 SUB: rd=rd-rs.
  - 4 ADDI: rd=rd+imm.
  - 5 JMP: PC=imm[3:0].
  - 6 BNZ: if rd!=0 then PC=imm[3:0].
  - All others are NOP. Arithmetic wraps modulo 256.
- **ROM** (16 words, 4-bit PC), addresses 0-5; addresses 6-15 hold 0x0000:
  - 0: 0x1003 (LI r0,3)
  - 1: 0x1401 (LI r1,1)
  - 2: 0x3100 (SUB r0,r1)
  - 3: 0x4805 (ADDI r2,5)
  - 4: 0x6002 (BNZ r0,2)
  - 5: 0x5005 (JMP 5)
- **Pipeline**: IF, ID, EX/WB, all updating only on a step pulse.
  - IF: IF/ID <= ROM[PC]; PC <= PC+1 (wraps 15 to 0).
  - ID: read operands into ID/EX. If EX is writing the same register this step, its result is forwarded instead.
  - EX: compute the result and write rd at the end of the step.
- **Control flow**:
  - A taken BNZ or a JMP in EX sets PC to the target and replaces IF/ID and ID/EX with NOP. Penalty is 2 steps.
  - The redirect overrides the sequential PC+1.
- **Step counter**: 16 bits, increments per step, wraps at 0xFFFF.
- **LCD FSM**:
  - Init sequence:
    - INIT_WAIT.
    - Single nibbles 0x3, 0x3, 0x3, 0x2, each followed by CHAR_GAP.
    - Commands 0x28, 0x06, 0x0C, then 0x01 followed by CLEAR_WAIT.
  - Refresh loop, forever: command 0x80, then 16 data bytes.
  - PC, the selected register and the step counter are snapshotted when command 0x80 is issued.
  - Display text "PC=hh Rn=hh ssss" in uppercase hex ASCII, where n = '0'+SW[1:0].

Test Plan:
- Hold BTN2=0 for 2 cycles, then release. LED=0, LCDE=0, LCDRW=0, PC=0, all registers 0, step count 0. No LCDE pulse before INIT_WAIT cycles elapse.
- Three BTN3 pulses, 70-cycle period. r0=3 after step 3, LED=1, step count 3.
- Steps 4-5: r1=1 after step 4, r0=2 after step 5. This exercises EX-to-ID forwarding of r1.
- 40 steps total. Final state: r0=0, r1=1, r2=0x0F, PC cycling 5/6/7 via JMP 5, step count 0x0028.
- SW=2, let the LCD complete a refresh. Line 1 shows "PC=0? R2=0F 0028": the first byte after 0x80 is 0x50 with LCDRS=1, sent as nibble 0x5 then 0x0.
- Assert BTN2 during an LCD byte transfer. LCDE drops the next cycle and the init sequence restarts after INIT_WAIT.
